// File: rtl/btn_led_toggle.sv
// -----------------------------------------------------------------------------
// btn_led_toggle
//
// Four independent push-button channels. Each channel synchronizes its raw
// button into the clock domain, debounces it, detects accepted presses and
// toggles an LED on every accepted press.
//
//   per channel: BTN[i] -> s1 -> s2 -> debouncer (stable, cnt)
//                       -> rising-edge detect -> led toggle / press strobe
//
// Parameters
//   DEBOUNCE_CYCLES  consecutive s2 cycles a new level must persist before it
//                    becomes the accepted level (legal 1 .. 2**24-1).
//
// Ports
//   clk        system clock, rising edge active
//   rstn       asynchronous active-low reset
//   BTN[3:0]   raw, asynchronous, bouncing buttons (1 = pressed)
//   LED0..LED3 toggle state per channel (1 = lit)
//   PRESS[3:0] one-cycle strobe per channel marking an accepted press
//
// Every output comes straight from a flop; BTN has no combinational path to
// any output.
// -----------------------------------------------------------------------------
module btn_led_toggle #(
    parameter int DEBOUNCE_CYCLES = 240000
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [3:0] BTN,
    output logic       LED0,
    output logic       LED1,
    output logic       LED2,
    output logic       LED3,
    output logic [3:0] PRESS
);

    // Counter only has to reach DEBOUNCE_CYCLES-1; keep at least one bit so
    // the DEBOUNCE_CYCLES = 1 case still elaborates.
    localparam int            CW      = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [3:0]         s1;       // first synchronizer stage
    logic [3:0]         s2;       // second synchronizer stage, feeds debouncer
    logic [3:0]         stable;   // accepted (debounced) level
    logic [3:0][CW-1:0] cnt;      // cycles s2 has differed from stable
    logic [3:0]         led;      // toggle state

    logic [3:0] differ;           // s2 disagrees with accepted level
    logic [3:0] at_max;           // counter has reached its terminal value
    logic [3:0] accept;           // s2 becomes the accepted level this edge
    logic [3:0] rise;             // accepted level goes 0 -> 1 this edge

    // The press is detected from the accept condition itself rather than from
    // a delayed copy of stable, so LED and PRESS update on the very edge that
    // stable flips.
    // NOTE: every always_comb output is assigned a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        differ = '0;
        at_max = '0;
        accept = '0;
        rise   = '0;
        for (int i = 0; i < 4; i++) begin
            differ[i] = s2[i] ^ stable[i];
            at_max[i] = (cnt[i] == CNT_MAX);
            accept[i] = differ[i] & at_max[i];
            rise[i]   = accept[i] & s2[i];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours (s2 <= s1 needs the old s1).
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            // NOTE: the per-channel counters are plain flops, not a RAM, so
            // they are cleared with the rest of the state; a reset mid-count
            // must abort any pending transition.
            s1     <= '0;
            s2     <= '0;
            stable <= '0;
            cnt    <= '0;
            led    <= '0;
            PRESS  <= '0;
        end else begin
            s1 <= BTN;
            s2 <= s1;

            for (int i = 0; i < 4; i++) begin
                if (!differ[i]) begin
                    // Any return to the accepted level restarts qualification.
                    cnt[i] <= '0;
                end else if (at_max[i]) begin
                    stable[i] <= s2[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end

            // Releases (stable 1 -> 0) leave both LED and PRESS untouched.
            led   <= led ^ rise;
            PRESS <= rise;
        end
    end

    assign LED0 = led[0];
    assign LED1 = led[1];
    assign LED2 = led[2];
    assign LED3 = led[3];

endmodule

// File: tb/tb_btn_led_toggle.sv
// -----------------------------------------------------------------------------
// tb_btn_led_toggle
//
// Directed bench for btn_led_toggle. Main instance uses DEBOUNCE_CYCLES = 4,
// a second instance uses DEBOUNCE_CYCLES = 1. Inputs change 1 time unit after
// a rising edge, outputs are sampled 1 time unit after a rising edge.
// -----------------------------------------------------------------------------
module tb_btn_led_toggle;

    localparam int DC = 4;

    logic       clk;
    logic       rstn;
    logic [3:0] btn;
    logic [3:0] btn1;
    logic       led0, led1, led2, led3;
    logic       l1_0, l1_1, l1_2, l1_3;
    logic [3:0] press;
    logic [3:0] press1;
    logic [3:0] leds;
    logic [3:0] leds1;

    assign leds  = {led3, led2, led1, led0};
    assign leds1 = {l1_3, l1_2, l1_1, l1_0};

    int errors = 0;
    int checks = 0;

    // Expected-state model for the main instance.
    logic [3:0] exp_led;
    logic [3:0] acc;    // level the model believes each channel has accepted

    btn_led_toggle #(.DEBOUNCE_CYCLES(DC)) dut (
        .clk   (clk),
        .rstn  (rstn),
        .BTN   (btn),
        .LED0  (led0),
        .LED1  (led1),
        .LED2  (led2),
        .LED3  (led3),
        .PRESS (press)
    );

    btn_led_toggle #(.DEBOUNCE_CYCLES(1)) dut1 (
        .clk   (clk),
        .rstn  (rstn),
        .BTN   (btn1),
        .LED0  (l1_0),
        .LED1  (l1_1),
        .LED2  (l1_2),
        .LED3  (l1_3),
        .PRESS (press1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Apply a clean level b and hold it n edges. A change accepted from a
    // fully settled previous level lands on the (DC+1)-th edge after the
    // first sampling edge, i.e. loop index j == DC+1 (j = 0 is that edge).
    task automatic run_phase(input logic [3:0] b, input int n, input string name);
        logic [3:0] rise;
        logic [3:0] exp_press;
        rise = b & ~acc;
        btn  = b;
        for (int j = 0; j < n; j++) begin
            tick();
            exp_press = 4'b0000;
            if (j == DC + 1) begin
                exp_led   = exp_led ^ rise;
                exp_press = rise;
            end
            check($sformatf("%s_led_e%0d", name, j), leds, exp_led);
            check($sformatf("%s_press_e%0d", name, j), press, exp_press);
        end
        acc = b;
    endtask

    // Apply a level that must not be accepted; outputs stay put.
    task automatic glitch(input logic [3:0] b, input int n);
        btn = b;
        for (int j = 0; j < n; j++) begin
            tick();
            check($sformatf("glitch_%b_led", b), leds, exp_led);
            check($sformatf("glitch_%b_press", b), press, 4'b0000);
        end
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        exp_led = 4'b0000;
        acc     = 4'b0000;
    endtask

    initial begin
        rstn    = 1'b1;
        btn     = 4'b0000;
        btn1    = 4'b0000;
        exp_led = 4'b0000;
        acc     = 4'b0000;

        // Asynchronous reset, applied without any clock edge.
        #2 rstn = 1'b0;
        #1;
        check("rst_leds",   leds,   4'b0000);
        check("rst_press",  press,  4'b0000);
        check("rst_leds1",  leds1,  4'b0000);
        check("rst_press1", press1, 4'b0000);
        tick();
        tick();
        rstn = 1'b1;

        // Idle: nothing pressed for 20 cycles.
        run_phase(4'b0000, 20, "idle");

        // Clean press on channel 0, held 50 cycles: one toggle, one strobe.
        run_phase(4'b0001, 50, "ch0_hold");
        run_phase(4'b0000, 10, "ch0_rel");
        check("ch0_after_release", leds, 4'b0001);

        // Bounce on channel 1: 3 high, 1 low, 3 high, then low.
        glitch(4'b0010, 3);
        glitch(4'b0000, 1);
        glitch(4'b0010, 3);
        glitch(4'b0000, 10);

        // Walking presses then all four together. Channel 3 is released
        // before the all-on phase so every channel re-qualifies at once.
        do_reset();
        run_phase(4'b0001, 10, "seq_0001");
        run_phase(4'b0010, 10, "seq_0010");
        run_phase(4'b0100, 10, "seq_0100");
        run_phase(4'b1000, 10, "seq_1000");
        run_phase(4'b0000, 10, "seq_gap");
        run_phase(4'b1111, 10, "seq_1111");
        run_phase(4'b0000, 10, "seq_0000");
        check("seq_final_leds", leds, 4'b0000);

        // Channel 2 held; reset pulsed while its counter sits at 2.
        do_reset();
        btn = 4'b0100;
        tick();            // first sampling edge: s1
        tick();            // s2
        tick();            // cnt = 1
        tick();            // cnt = 2
        check("ch2_pre_rst_led", leds, 4'b0000);
        #2 rstn = 1'b0;
        #1;
        check("ch2_rst_async_led",   leds,  4'b0000);
        check("ch2_rst_async_press", press, 4'b0000);
        for (int j = 0; j < 3; j++) begin
            tick();
            check("ch2_rst_hold_led",   leds,  4'b0000);
            check("ch2_rst_hold_press", press, 4'b0000);
        end
        // Two qualification passes; the first is aborted by a reset that
        // lands in the middle of its PRESS strobe.
        for (int pass = 0; pass < 2; pass++) begin
            rstn = 1'b1;
            for (int j = 0; j <= DC + 1; j++) begin
                tick();
                check($sformatf("ch2_requal%0d_led_e%0d", pass, j), leds,
                      (j == DC + 1) ? 4'b0100 : 4'b0000);
                check($sformatf("ch2_requal%0d_press_e%0d", pass, j), press,
                      (j == DC + 1) ? 4'b0100 : 4'b0000);
            end
            if (pass == 0) begin
                #2 rstn = 1'b0;
                #1;
                check("ch2_strobe_rst_led",   leds,  4'b0000);
                check("ch2_strobe_rst_press", press, 4'b0000);
                tick();
            end
        end
        exp_led = 4'b0100;
        acc     = 4'b0100;
        for (int j = 0; j < 10; j++) begin
            tick();
            check("ch2_held_led",   leds,  4'b0100);
            check("ch2_held_press", press, 4'b0000);
        end
        run_phase(4'b0000, 10, "ch2_rel");

        // DEBOUNCE_CYCLES = 1: toggle two edges after the first sampling edge.
        for (int pass = 0; pass < 2; pass++) begin
            btn1 = 4'b0001;
            for (int j = 0; j < 8; j++) begin
                tick();
                check($sformatf("dc1_p%0d_led_e%0d", pass, j), leds1,
                      (j >= 2) ? ((pass == 0) ? 4'b0001 : 4'b0000)
                               : ((pass == 0) ? 4'b0000 : 4'b0001));
                check($sformatf("dc1_p%0d_press_e%0d", pass, j), press1,
                      (j == 2) ? 4'b0001 : 4'b0000);
            end
            btn1 = 4'b0000;
            for (int j = 0; j < 4; j++) begin
                tick();
                check($sformatf("dc1_p%0d_rel_press", pass), press1, 4'b0000);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
